// File: rtl/serializator_arbiter.sv
// Round-robin arbiter/sequencer sharing one serializator between N requesters.
// Illegal length codes are consumed and counted without touching the serializer.
module serializator_arbiter #(
    parameter int N     = 4,
    parameter int CNT_W = 8
) (
    input  logic                 clk_i,
    input  logic                 srst_i,
    input  logic [N*16-1:0]      req_data_i,
    input  logic [N*4-1:0]       req_mod_i,
    input  logic [N-1:0]         req_val_i,
    output logic [N-1:0]         req_ready_o,
    output logic [15:0]          ser_data_o,
    output logic [3:0]           ser_data_mod_o,
    output logic                 ser_data_val_o,
    input  logic                 ser_busy_i,
    output logic [$clog2(N)-1:0] grant_id_o,
    output logic                 drop_o,
    output logic [CNT_W-1:0]     frame_cnt_o,
    output logic [CNT_W-1:0]     drop_cnt_o
);

    localparam int IW = $clog2(N);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_START,
        WAIT_DONE
    } state_t;

    state_t         state_q, state_d;
    logic [IW-1:0]  ptr_q, ptr_d;
    logic [N-1:0]   ready_d;
    logic [15:0]    data_d;
    logic [3:0]     mod_d;
    logic           val_d;
    logic [IW-1:0]  gid_d;
    logic           drop_d;
    logic [CNT_W-1:0] fcnt_d, dcnt_d;

    logic [15:0]    data_a [N];
    logic [3:0]     mod_a  [N];
    logic [N-1:0]   cand;
    logic           found;
    logic [IW-1:0]  sel;
    logic [IW-1:0]  idx;
    logic           illegal;

    always_comb begin
        for (int k = 0; k < N; k++) begin
            data_a[k] = req_data_i[k*16 +: 16];
            mod_a[k]  = req_mod_i[k*4 +: 4];
        end
    end

    // A requester whose ready pulse is showing has already been consumed.
    always_comb begin
        cand  = req_val_i & ~req_ready_o;
        found = 1'b0;
        sel   = '0;
        idx   = '0;
        for (int i = 0; i < N; i++) begin
            idx = IW'((int'(ptr_q) + i) % N);
            if (!found && cand[idx]) begin
                found = 1'b1;
                sel   = idx;
            end
        end
        illegal = (mod_a[sel] == 4'd1) || (mod_a[sel] == 4'd2);
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        ready_d = '0;
        val_d   = 1'b0;
        drop_d  = 1'b0;
        data_d  = ser_data_o;
        mod_d   = ser_data_mod_o;
        gid_d   = grant_id_o;
        fcnt_d  = frame_cnt_o;
        dcnt_d  = drop_cnt_o;
        unique case (state_q)
            IDLE: begin
                if (!ser_busy_i && found) begin
                    ready_d[sel] = 1'b1;
                    ptr_d = (sel == IW'(N-1)) ? '0 : sel + 1'b1;
                    if (illegal) begin
                        drop_d = 1'b1;
                        dcnt_d = drop_cnt_o + 1'b1;
                    end else begin
                        data_d  = data_a[sel];
                        mod_d   = mod_a[sel];
                        gid_d   = sel;
                        val_d   = 1'b1;
                        fcnt_d  = frame_cnt_o + 1'b1;
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE:      state_d = WAIT_START;
            WAIT_START: if (ser_busy_i) state_d = WAIT_DONE;
            WAIT_DONE:  if (!ser_busy_i) state_d = IDLE;
            default:    state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            state_q        <= IDLE;
            ptr_q          <= '0;
            req_ready_o    <= '0;
            ser_data_o     <= '0;
            ser_data_mod_o <= '0;
            ser_data_val_o <= 1'b0;
            grant_id_o     <= '0;
            drop_o         <= 1'b0;
            frame_cnt_o    <= '0;
            drop_cnt_o     <= '0;
        end else begin
            state_q        <= state_d;
            ptr_q          <= ptr_d;
            req_ready_o    <= ready_d;
            ser_data_o     <= data_d;
            ser_data_mod_o <= mod_d;
            ser_data_val_o <= val_d;
            grant_id_o     <= gid_d;
            drop_o         <= drop_d;
            frame_cnt_o    <= fcnt_d;
            drop_cnt_o     <= dcnt_d;
        end
    end

endmodule

// File: tb/tb_serializator_arbiter.sv
// Directed bench for serializator_arbiter with a behavioural serializer
// and a scoreboard of expected loads.
module tb_serializator_arbiter;

    localparam int N = 4;
    localparam int CNT_W = 8;

    logic            clk_i = 1'b0;
    logic            srst_i = 1'b1;
    logic [N*16-1:0] req_data_i = '0;
    logic [N*4-1:0]  req_mod_i = '0;
    logic [N-1:0]    req_val_i = '0;
    logic [N-1:0]    req_ready_o;
    logic [15:0]     ser_data_o;
    logic [3:0]      ser_data_mod_o;
    logic            ser_data_val_o;
    logic            ser_busy_i;
    logic [1:0]      grant_id_o;
    logic            drop_o;
    logic [CNT_W-1:0] frame_cnt_o;
    logic [CNT_W-1:0] drop_cnt_o;

    serializator_arbiter #(.N(N), .CNT_W(CNT_W)) dut (
        .clk_i          (clk_i),
        .srst_i         (srst_i),
        .req_data_i     (req_data_i),
        .req_mod_i      (req_mod_i),
        .req_val_i      (req_val_i),
        .req_ready_o    (req_ready_o),
        .ser_data_o     (ser_data_o),
        .ser_data_mod_o (ser_data_mod_o),
        .ser_data_val_o (ser_data_val_o),
        .ser_busy_i     (ser_busy_i),
        .grant_id_o     (grant_id_o),
        .drop_o         (drop_o),
        .frame_cnt_o    (frame_cnt_o),
        .drop_cnt_o     (drop_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    // Serializer model: busy rises the cycle after a load, lasts one cycle per bit.
    logic       busy_m = 1'b0;
    logic [4:0] rem_m = '0;
    logic       force_busy = 1'b0;
    assign ser_busy_i = busy_m | force_busy;

    always @(posedge clk_i) begin
        if (srst_i) begin
            busy_m <= 1'b0;
            rem_m  <= '0;
        end else if (ser_data_val_o) begin
            busy_m <= 1'b1;
            rem_m  <= (ser_data_mod_o == 4'd0) ? 5'd15 : {1'b0, ser_data_mod_o} - 5'd1;
        end else if (busy_m) begin
            if (rem_m == 5'd0) busy_m <= 1'b0;
            else rem_m <= rem_m - 5'd1;
        end
    end

    typedef struct {
        logic [15:0] d;
        logic [3:0]  m;
        logic [3:0]  r;
        logic [1:0]  g;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int failures = 0;

    int          refill [N] = '{default: 0};
    logic [15:0] next_d [N];
    logic [3:0]  next_m [N];
    logic        hold = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [15:0] d, input logic [3:0] m, input int k);
        exp_t e;
        e.d = d;
        e.m = m;
        e.r = 4'(1 << k);
        e.g = 2'(k);
        sb.push_back(e);
    endtask

    task automatic set_req(input int k, input logic [15:0] d, input logic [3:0] m);
        req_data_i[k*16 +: 16] = d;
        req_mod_i[k*4 +: 4]    = m;
        req_val_i[k]           = 1'b1;
    endtask

    // Requesters react to their ready pulse: next word or drop valid.
    task automatic tick();
        @(posedge clk_i);
        #1;
        if (!hold) begin
            for (int k = 0; k < N; k++) begin
                if (req_ready_o[k]) begin
                    if (refill[k] > 0) begin
                        refill[k]--;
                        req_data_i[k*16 +: 16] = next_d[k];
                        req_mod_i[k*4 +: 4]    = next_m[k];
                    end else begin
                        req_val_i[k] = 1'b0;
                    end
                end
            end
        end
    endtask

    task automatic wait_quiet(input int budget);
        int n = 0;
        while ((sb.size() != 0 || ser_busy_i || ser_data_val_o) && n < budget) begin
            tick();
            n++;
        end
        chk("quiet_timeout", 32'(n < budget), 32'd1);
        tick();
    endtask

    always @(negedge clk_i) begin
        if (!srst_i && ser_data_val_o) begin
            chk("load_while_busy", 32'(ser_busy_i), 32'd0);
            if (sb.size() == 0) begin
                chk("unexpected_load", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("load_data", 32'(ser_data_o), 32'(e.d));
                chk("load_mod", 32'(ser_data_mod_o), 32'(e.m));
                chk("load_ready", 32'(req_ready_o), 32'(e.r));
                chk("load_gid", 32'(grant_id_o), 32'(e.g));
            end
        end
    end

    initial begin
        int n;
        logic bad;

        // Reset state
        tick();
        tick();
        srst_i = 1'b0;
        chk("rst_ready", 32'(req_ready_o), 32'd0);
        chk("rst_val", 32'(ser_data_val_o), 32'd0);
        chk("rst_data", 32'(ser_data_o), 32'd0);
        chk("rst_mod", 32'(ser_data_mod_o), 32'd0);
        chk("rst_gid", 32'(grant_id_o), 32'd0);
        chk("rst_drop", 32'(drop_o), 32'd0);
        chk("rst_fcnt", 32'(frame_cnt_o), 32'd0);
        chk("rst_dcnt", 32'(drop_cnt_o), 32'd0);

        // Single request, then a second word that must wait for the frame
        set_req(0, 16'hA5C3, 4'd0);
        refill[0] = 1;
        next_d[0] = 16'h1234;
        next_m[0] = 4'd3;
        push(16'hA5C3, 4'd0, 0);
        push(16'h1234, 4'd3, 0);
        tick();
        chk("t1_val", 32'(ser_data_val_o), 32'd1);
        chk("t1_ready", 32'(req_ready_o), 32'h1);
        chk("t1_data", 32'(ser_data_o), 32'hA5C3);
        chk("t1_fcnt", 32'(frame_cnt_o), 32'd1);
        n = 0;
        while (!ser_busy_i && n < 10) begin tick(); n++; end
        chk("t1_busy_rise", 32'(ser_busy_i), 32'd1);
        n = 0;
        while (ser_busy_i && n < 40) begin tick(); n++; end
        chk("t1_busy_fall", 32'(ser_busy_i), 32'd0);
        chk("t1_noval_t", 32'(ser_data_val_o), 32'd0);
        tick();
        chk("t1_noval_t1", 32'(ser_data_val_o), 32'd0);
        tick();
        chk("t1_val_t2", 32'(ser_data_val_o), 32'd1);
        chk("t1_fcnt2", 32'(frame_cnt_o), 32'd2);
        wait_quiet(50);

        // Reset in IDLE to restart the pointer at 0
        srst_i = 1'b1;
        tick();
        srst_i = 1'b0;

        // All four requesters continuously valid, mod 5
        for (int k = 0; k < N; k++) begin
            set_req(k, 16'hB000 | 16'(k << 4), 4'd5);
            push(16'hB000 | 16'(k << 4), 4'd5, k);
        end
        refill[0] = 1;
        next_d[0] = 16'hB001;
        next_m[0] = 4'd5;
        push(16'hB001, 4'd5, 0);
        wait_quiet(200);
        chk("t2_fcnt", 32'(frame_cnt_o), 32'd5);

        // Illegal mod dropped, legal neighbour loaded next cycle
        set_req(2, 16'hDEAD, 4'd1);
        set_req(3, 16'h3333, 4'd4);
        push(16'h3333, 4'd4, 3);
        tick();
        chk("t3_drop", 32'(drop_o), 32'd1);
        chk("t3_ready", 32'(req_ready_o), 32'h4);
        chk("t3_dcnt", 32'(drop_cnt_o), 32'd1);
        chk("t3_noval", 32'(ser_data_val_o), 32'd0);
        tick();
        chk("t3_val", 32'(ser_data_val_o), 32'd1);
        chk("t3_ready3", 32'(req_ready_o), 32'h8);
        chk("t3_drop_clr", 32'(drop_o), 32'd0);
        wait_quiet(50);

        // Busy held high in IDLE blocks arbitration
        force_busy = 1'b1;
        set_req(1, 16'h0101, 4'd3);
        push(16'h0101, 4'd3, 1);
        bad = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (req_ready_o != '0 || ser_data_val_o) bad = 1'b1;
        end
        chk("t4_blocked", 32'(bad), 32'd0);
        force_busy = 1'b0;
        tick();
        chk("t4_val", 32'(ser_data_val_o), 32'd1);
        chk("t4_ready", 32'(req_ready_o), 32'h2);
        wait_quiet(50);

        // Reset in WAIT_DONE
        set_req(0, 16'h7777, 4'd0);
        push(16'h7777, 4'd0, 0);
        tick();
        for (int i = 0; i < 4; i++) tick();
        chk("t5_busy", 32'(ser_busy_i), 32'd1);
        srst_i = 1'b1;
        tick();
        chk("t5_ready", 32'(req_ready_o), 32'd0);
        chk("t5_val", 32'(ser_data_val_o), 32'd0);
        chk("t5_data", 32'(ser_data_o), 32'd0);
        chk("t5_mod", 32'(ser_data_mod_o), 32'd0);
        chk("t5_gid", 32'(grant_id_o), 32'd0);
        chk("t5_drop", 32'(drop_o), 32'd0);
        chk("t5_fcnt", 32'(frame_cnt_o), 32'd0);
        chk("t5_dcnt", 32'(drop_cnt_o), 32'd0);
        srst_i = 1'b0;
        set_req(0, 16'h0A0A, 4'd3);
        set_req(1, 16'h1B1B, 4'd3);
        push(16'h0A0A, 4'd3, 0);
        push(16'h1B1B, 4'd3, 1);
        tick();
        chk("t5_first_gid", 32'(grant_id_o), 32'd0);
        chk("t5_first_ready", 32'(req_ready_o), 32'h1);
        chk("t5_fcnt1", 32'(frame_cnt_o), 32'd1);
        wait_quiet(60);

        // Drop counter wrap
        hold = 1'b1;
        set_req(0, 16'hEEEE, 4'd2);
        set_req(1, 16'hFFFF, 4'd2);
        for (int i = 0; i < 255; i++) tick();
        chk("t6_dcnt255", 32'(drop_cnt_o), 32'hFF);
        tick();
        chk("t6_dcnt_wrap", 32'(drop_cnt_o), 32'h00);
        chk("t6_drop", 32'(drop_o), 32'd1);
        req_val_i = '0;
        hold = 1'b0;
        tick();
        tick();
        chk("t6_drop_clr", 32'(drop_o), 32'd0);
        chk("t6_fcnt", 32'(frame_cnt_o), 32'd2);
        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
